multicycle_sequencer: RTL and testbench

Parametrised multicycle control sequencer for the 54-instruction MIPS core, sitting between the instruction decoder and the datapath strobes. It walks each instruction through a one-hot phase machine whose path depends on the instruction class, given as mask parameters. Unlike the fixed 4-phase controller, it adds:
- a stall for memory wait states;
- a bounded wait for the multiply/divide unit's busy flag;
- conditional and illegal-instruction traps;
- a retired-instruction counter.

---
 rtl/mc_seq_pkg.sv | 40 ++++
 rtl/mc_wait_timer.sv | 31 +++
 rtl/multicycle_sequencer.sv | 157 +++++++++++++++
 tb/tb_multicycle_sequencer.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_seq_pkg.sv
// Shared definitions for the multicycle control sequencer: phase encoding,
// instruction classes and trap cause codes.
package mc_seq_pkg;

    localparam int S_FETCH  = 0;
    localparam int S_DECODE = 1;
    localparam int S_EXEC   = 2;
    localparam int S_MDWAIT = 3;
    localparam int S_MEM    = 4;
    localparam int S_WB     = 5;
    localparam int S_TRAP   = 6;

    typedef enum logic [6:0] {
        ST_FETCH  = 7'b0000001,
        ST_DECODE = 7'b0000010,
        ST_EXEC   = 7'b0000100,
        ST_MDWAIT = 7'b0001000,
        ST_MEM    = 7'b0010000,
        ST_WB     = 7'b0100000,
        ST_TRAP   = 7'b1000000
    } state_e;

    typedef enum logic [2:0] {
        CL_ILLEGAL,
        CL_JUMP,
        CL_SHORT,
        CL_MULDIV,
        CL_MEM,
        CL_TRAP,
        CL_ALU
    } instr_class_e;

    // SYS and BRK are raised by cp0, not by this sequencer.
    localparam logic [4:0] CAUSE_RI  = 5'b01010;
    localparam logic [4:0] CAUSE_TO  = 5'b01100;
    localparam logic [4:0] CAUSE_TEQ = 5'b01101;
    localparam logic [4:0] CAUSE_SYS = 5'b01000;
    localparam logic [4:0] CAUSE_BRK = 5'b01001;

endpackage

// File: rtl/mc_wait_timer.sv
// Clear/enable wait counter for the mul/div busy wait; saturates at MAX_WAIT
// and flags both "has counted at least once" and "reached the limit".
module mc_wait_timer #(
    parameter int MAX_WAIT = 64
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_nonzero,
    output logic o_expired
);

    localparam int W = $clog2(MAX_WAIT + 1);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_expired) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_nonzero = (r_count != '0);
    assign o_expired = (r_count == W'(MAX_WAIT));

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle control sequencer: walks each decoded instruction through a
// one-hot phase machine whose path depends on its class.
module multicycle_sequencer
    import mc_seq_pkg::*;
#(
    parameter int                   N_INSTR     = 54,
    parameter logic [N_INSTR-1:0]   JUMP_MASK   = '0,
    parameter logic [N_INSTR-1:0]   SHORT_MASK  = '0,
    parameter logic [N_INSTR-1:0]   MULDIV_MASK = '0,
    parameter logic [N_INSTR-1:0]   MEM_MASK    = '0,
    parameter logic [N_INSTR-1:0]   TRAP_MASK   = '0,
    parameter int                   MAX_WAIT    = 64,
    parameter int                   CNT_W       = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_INSTR-1:0] decoded_instr,
    input  logic               zero,
    input  logic               busy,
    input  logic               mem_ready,
    output logic [6:0]         state,
    output logic               pc_ena,
    output logic               ir_in,
    output logic               decode_ena,
    output logic               md_start,
    output logic               regfile_w,
    output logic               trap_valid,
    output logic [4:0]         trap_cause,
    output logic               instr_done,
    output logic [CNT_W-1:0]   retired
);

    state_e       r_state;
    logic         r_pc_ena;
    logic         r_decode_ena;
    logic         r_regfile_w;
    logic         r_trap_valid;
    logic [4:0]   r_trap_cause;
    logic [CNT_W-1:0] r_retired;

    state_e       w_next;
    logic [4:0]   w_next_cause;
    instr_class_e w_class;
    logic         w_onehot;
    logic         w_in_mdwait;
    logic         w_wait_nz;
    logic         w_wait_exp;

    assign w_onehot = (decoded_instr != '0) &&
                      ((decoded_instr & (decoded_instr - N_INSTR'(1))) == '0);

    always_comb begin
        w_class = CL_ALU;
        if (!w_onehot)                           w_class = CL_ILLEGAL;
        else if (|(decoded_instr & JUMP_MASK))   w_class = CL_JUMP;
        else if (|(decoded_instr & SHORT_MASK))  w_class = CL_SHORT;
        else if (|(decoded_instr & MULDIV_MASK)) w_class = CL_MULDIV;
        else if (|(decoded_instr & MEM_MASK))    w_class = CL_MEM;
        else if (|(decoded_instr & TRAP_MASK))   w_class = CL_TRAP;
    end

    assign w_in_mdwait = (r_state == ST_MDWAIT);

    mc_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .i_clk     (clk),
        .i_rst_n   (rst),
        .i_clear   (!w_in_mdwait),
        .i_enable  (w_in_mdwait),
        .o_nonzero (w_wait_nz),
        .o_expired (w_wait_exp)
    );

    // busy and mem_ready are level status flags, not handshakes: the sequencer
    // samples them only in MDWAIT/MEM and holds the phase until they release.
    always_comb begin
        w_next       = r_state;
        w_next_cause = 5'd0;
        case (r_state)
            ST_FETCH: w_next = ST_DECODE;
            ST_DECODE: begin
                case (w_class)
                    CL_ILLEGAL: begin
                        w_next       = ST_TRAP;
                        w_next_cause = CAUSE_RI;
                    end
                    CL_JUMP:   w_next = ST_FETCH;
                    CL_SHORT:  w_next = ST_WB;
                    CL_MULDIV: w_next = ST_MDWAIT;
                    default:   w_next = ST_EXEC;
                endcase
            end
            ST_EXEC: begin
                if (w_class == CL_MEM) begin
                    w_next = ST_MEM;
                end else if (w_class == CL_TRAP) begin
                    if (zero) begin
                        w_next       = ST_TRAP;
                        w_next_cause = CAUSE_TEQ;
                    end else begin
                        w_next = ST_FETCH;
                    end
                end else begin
                    w_next = ST_WB;
                end
            end
            ST_MDWAIT: begin
                if (!busy && w_wait_nz) begin
                    w_next = ST_WB;
                end else if (busy && w_wait_exp) begin
                    w_next       = ST_TRAP;
                    w_next_cause = CAUSE_TO;
                end
            end
            ST_MEM: begin
                if (mem_ready) w_next = ST_WB;
            end
            ST_WB:   w_next = ST_FETCH;
            ST_TRAP: w_next = ST_FETCH;
            default: w_next = ST_FETCH;
        endcase
    end

    assign md_start   = (r_state == ST_DECODE) && (w_class == CL_MULDIV);
    assign instr_done = rst && (w_next == ST_FETCH);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_FETCH;
            r_pc_ena     <= 1'b1;
            r_decode_ena <= 1'b0;
            r_regfile_w  <= 1'b0;
            r_trap_valid <= 1'b0;
            r_trap_cause <= 5'd0;
            r_retired    <= '0;
        end else begin
            r_state      <= w_next;
            r_pc_ena     <= (w_next == ST_FETCH);
            r_decode_ena <= (w_next == ST_DECODE);
            r_regfile_w  <= (w_next == ST_WB);
            r_trap_valid <= (w_next == ST_TRAP);
            r_trap_cause <= w_next_cause;
            if (instr_done) r_retired <= r_retired + CNT_W'(1);
        end
    end

    assign state      = r_state;
    assign pc_ena     = r_pc_ena;
    assign ir_in      = r_pc_ena;
    assign decode_ena = r_decode_ena;
    assign regfile_w  = r_regfile_w;
    assign trap_valid = r_trap_valid;
    assign trap_cause = r_trap_cause;
    assign retired    = r_retired;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: two instances (long wait/32-bit counter and
// short wait/3-bit counter) checked cycle by cycle against a phase-list model.
module tb_multicycle_sequencer;

    localparam int N = 54;
    localparam logic [N-1:0] JUMP_M   = (54'd1 << 16) | (54'd1 << 17);
    localparam logic [N-1:0] SHORT_M  = (54'h3F << 40);
    localparam logic [N-1:0] MULDIV_M = (54'hF << 24) | (54'd1 << 46);
    localparam logic [N-1:0] MEM_M    = (54'hFF << 30) | (54'd1 << 45) | (54'd1 << 47);
    localparam logic [N-1:0] TRAP_M   = (54'd1 << 50) | (54'd1 << 46) | (54'd1 << 47);

    localparam int C_ILL = 0, C_JUMP = 1, C_SHORT = 2, C_MD = 3, C_MEM = 4, C_TRAP = 5, C_ALU = 6;

    // ---------------- clock / reset / DUTs ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [N-1:0] decoded_instr = '0;
    logic zero = 1'b0, busy = 1'b0, mem_ready = 1'b0;

    always #5 clk = ~clk;

    logic [6:0]  state_a, state_b;
    logic        pc_ena_a, ir_in_a, decode_ena_a, md_start_a, regfile_w_a, trap_valid_a, instr_done_a;
    logic        pc_ena_b, ir_in_b, decode_ena_b, md_start_b, regfile_w_b, trap_valid_b, instr_done_b;
    logic [4:0]  trap_cause_a, trap_cause_b;
    logic [31:0] retired_a;
    logic [2:0]  retired_b;

    multicycle_sequencer #(
        .N_INSTR(N), .JUMP_MASK(JUMP_M), .SHORT_MASK(SHORT_M), .MULDIV_MASK(MULDIV_M),
        .MEM_MASK(MEM_M), .TRAP_MASK(TRAP_M), .MAX_WAIT(64), .CNT_W(32)
    ) dut_a (
        .clk(clk), .rst(rst), .decoded_instr(decoded_instr), .zero(zero), .busy(busy),
        .mem_ready(mem_ready), .state(state_a), .pc_ena(pc_ena_a), .ir_in(ir_in_a),
        .decode_ena(decode_ena_a), .md_start(md_start_a), .regfile_w(regfile_w_a),
        .trap_valid(trap_valid_a), .trap_cause(trap_cause_a), .instr_done(instr_done_a),
        .retired(retired_a)
    );

    multicycle_sequencer #(
        .N_INSTR(N), .JUMP_MASK(JUMP_M), .SHORT_MASK(SHORT_M), .MULDIV_MASK(MULDIV_M),
        .MEM_MASK(MEM_M), .TRAP_MASK(TRAP_M), .MAX_WAIT(8), .CNT_W(3)
    ) dut_b (
        .clk(clk), .rst(rst), .decoded_instr(decoded_instr), .zero(zero), .busy(busy),
        .mem_ready(mem_ready), .state(state_b), .pc_ena(pc_ena_b), .ir_in(ir_in_b),
        .decode_ena(decode_ena_b), .md_start(md_start_b), .regfile_w(regfile_w_b),
        .trap_valid(trap_valid_b), .trap_cause(trap_cause_b), .instr_done(instr_done_b),
        .retired(retired_b)
    );

    logic [50:0] obs_a;
    logic [21:0] obs_b;
    assign obs_a = {state_a, pc_ena_a, ir_in_a, decode_ena_a, md_start_a, regfile_w_a,
                    trap_valid_a, trap_cause_a, instr_done_a, retired_a};
    assign obs_b = {state_b, pc_ena_b, ir_in_b, decode_ena_b, md_start_b, regfile_w_b,
                    trap_valid_b, trap_cause_b, instr_done_b, retired_b};

    // ---------------- reference model ----------------
    int n_chk = 0;
    int n_fail = 0;
    int ret_model = 0;

    logic [N-1:0] cur_instr;
    int           cur_cl, cur_stall, cur_busy_n;
    logic         cur_z;

    logic [18:0] tr[$];
    logic [50:0] exp_a_q[$];
    logic [21:0] exp_b_q[$];
    logic [50:0] obs_a_q[$];
    logic [21:0] obs_b_q[$];

    function automatic int classify(logic [N-1:0] v);
        if ($countones(v) != 1)   return C_ILL;
        if ((v & JUMP_M) != '0)   return C_JUMP;
        if ((v & SHORT_M) != '0)  return C_SHORT;
        if ((v & MULDIV_M) != '0) return C_MD;
        if ((v & MEM_M) != '0)    return C_MEM;
        if ((v & TRAP_M) != '0)   return C_TRAP;
        return C_ALU;
    endfunction

    // Phase numbers are the one-hot bit positions: F D E MD M W T.
    function automatic logic [18:0] ctl(int ph, logic [4:0] cause, bit md, bit done);
        logic [6:0] oh;
        oh = 7'd1 << ph;
        return {oh, ph == 0, ph == 0, ph == 1, md, ph == 5, ph == 6,
                (ph == 6) ? cause : 5'd0, done};
    endfunction

    task automatic expand(input int max_wait);
        int ph[$];
        logic [4:0] cause;
        int k;
        cause = 5'd0;
        ph.push_back(0);
        ph.push_back(1);
        case (cur_cl)
            C_ILL: begin ph.push_back(6); cause = 5'b01010; end
            C_JUMP: begin end
            C_SHORT: ph.push_back(5);
            C_MD: begin
                if (cur_busy_n > max_wait) begin
                    repeat (max_wait + 1) ph.push_back(3);
                    ph.push_back(6);
                    cause = 5'b01100;
                end else begin
                    k = (cur_busy_n + 1 > 2) ? cur_busy_n + 1 : 2;
                    repeat (k) ph.push_back(3);
                    ph.push_back(5);
                end
            end
            C_MEM: begin
                ph.push_back(2);
                repeat (cur_stall + 1) ph.push_back(4);
                ph.push_back(5);
            end
            C_TRAP: begin
                ph.push_back(2);
                if (cur_z) begin ph.push_back(6); cause = 5'b01101; end
            end
            default: begin ph.push_back(2); ph.push_back(5); end
        endcase
        tr.delete();
        foreach (ph[i])
            tr.push_back(ctl(ph[i], cause, (cur_cl == C_MD) && (ph[i] == 1), i == ph.size() - 1));
    endtask

    task automatic plan(input logic [N-1:0] instr, input int stall, input int busy_n, input logic z);
        cur_instr  = instr;
        cur_cl     = classify(instr);
        cur_stall  = stall;
        cur_busy_n = busy_n;
        cur_z      = z;
        expand(64);
        exp_a_q.delete();
        foreach (tr[i]) exp_a_q.push_back({tr[i], 32'(ret_model)});
        expand(8);
        exp_b_q.delete();
        foreach (tr[i]) exp_b_q.push_back({tr[i], 3'(ret_model)});
        ret_model++;
    endtask

    // ---------------- driver ----------------
    // Entered at a falling edge; each iteration is one clock cycle of the instruction.
    task automatic drive_instr(input int n);
        obs_a_q.delete();
        obs_b_q.delete();
        for (int c = 0; c < n; c++) begin
            decoded_instr = (c == 0) ? N'({$urandom, $urandom}) : cur_instr;
            busy      = (cur_cl == C_MD && c >= 2) ? (c - 2 < cur_busy_n) : 1'($urandom_range(0, 1));
            mem_ready = (cur_cl == C_MEM && c >= 3) ? (c - 3 >= cur_stall) : 1'($urandom_range(0, 1));
            zero      = (cur_cl == C_TRAP && c == 2) ? cur_z : 1'($urandom_range(0, 1));
            #1;
            obs_a_q.push_back(obs_a);
            obs_b_q.push_back(obs_b);
            @(negedge clk);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        decoded_instr = N'({$urandom, $urandom});
        @(negedge clk);
        rst = 1'b1;
        ret_model = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            decoded_instr = N'({$urandom, $urandom});
            busy = 1'($urandom_range(0, 1));
            mem_ready = 1'($urandom_range(0, 1));
            zero = 1'($urandom_range(0, 1));
            @(negedge clk);
            #1;
            n_chk++;
            if (obs_a !== {ctl(0, 5'd0, 0, 0), 32'd0} || obs_b !== {ctl(0, 5'd0, 0, 0), 3'd0}) begin
                n_fail++;
                $display("FAIL reset[%0d]: got a=%h b=%h exp a=%h b=%h", k, obs_a, obs_b,
                         {ctl(0, 5'd0, 0, 0), 32'd0}, {ctl(0, 5'd0, 0, 0), 3'd0});
            end
        end
        @(negedge clk);
        rst = 1'b1;
        ret_model = 0;
    endtask

    task automatic test_jump();
        for (int k = 16; k <= 17; k++) begin
            plan(54'd1 << k, 0, 0, 1'b0);
            drive_instr(exp_a_q.size());
            foreach (exp_a_q[i]) begin
                n_chk++;
                if (obs_a_q[i] !== exp_a_q[i] || obs_b_q[i] !== exp_b_q[i]) begin
                    n_fail++;
                    $display("FAIL jump bit%0d cyc%0d: got a=%h b=%h exp a=%h b=%h",
                             k, i, obs_a_q[i], obs_b_q[i], exp_a_q[i], exp_b_q[i]);
                end
            end
        end
    endtask

    task automatic test_alu_short();
        int bits[3] = '{3, 40, 44};
        foreach (bits[k]) begin
            plan(54'd1 << bits[k], 0, 0, 1'b0);
            drive_instr(exp_a_q.size());
            foreach (exp_a_q[i]) begin
                n_chk++;
                if (obs_a_q[i] !== exp_a_q[i] || obs_b_q[i] !== exp_b_q[i]) begin
                    n_fail++;
                    $display("FAIL alu_short bit%0d cyc%0d: got a=%h b=%h exp a=%h b=%h",
                             bits[k], i, obs_a_q[i], obs_b_q[i], exp_a_q[i], exp_b_q[i]);
                end
            end
        end
    endtask

    task automatic test_mem_stall();
        int stalls[3] = '{3, 0, 1};
        foreach (stalls[k]) begin
            plan(54'd1 << 30, stalls[k], 0, 1'b0);
            drive_instr(exp_a_q.size());
            foreach (exp_a_q[i]) begin
                n_chk++;
                if (obs_a_q[i] !== exp_a_q[i] || obs_b_q[i] !== exp_b_q[i]) begin
                    n_fail++;
                    $display("FAIL mem_stall s%0d cyc%0d: got a=%h b=%h exp a=%h b=%h",
                             stalls[k], i, obs_a_q[i], obs_b_q[i], exp_a_q[i], exp_b_q[i]);
                end
            end
        end
    endtask

    task automatic test_muldiv();
        int waits[3] = '{0, 1, 8};
        foreach (waits[k]) begin
            plan(54'd1 << 26, 0, waits[k], 1'b0);
            drive_instr(exp_a_q.size());
            foreach (exp_a_q[i]) begin
                n_chk++;
                if (obs_a_q[i] !== exp_a_q[i] || obs_b_q[i] !== exp_b_q[i]) begin
                    n_fail++;
                    $display("FAIL muldiv busy%0d cyc%0d: got a=%h b=%h exp a=%h b=%h",
                             waits[k], i, obs_a_q[i], obs_b_q[i], exp_a_q[i], exp_b_q[i]);
                end
            end
        end
    endtask

    task automatic test_teq();
        for (int z = 1; z >= 0; z--) begin
            plan(54'd1 << 50, 0, 0, 1'(z));
            drive_instr(exp_a_q.size());
            foreach (exp_a_q[i]) begin
                n_chk++;
                if (obs_a_q[i] !== exp_a_q[i] || obs_b_q[i] !== exp_b_q[i]) begin
                    n_fail++;
                    $display("FAIL teq z%0d cyc%0d: got a=%h b=%h exp a=%h b=%h",
                             z, i, obs_a_q[i], obs_b_q[i], exp_a_q[i], exp_b_q[i]);
                end
            end
        end
    endtask

    task automatic test_illegal();
        logic [N-1:0] ill[3];
        ill[0] = '0;
        ill[1] = (54'd1 << 3) | (54'd1 << 16);
        ill[2] = (54'd1 << 26) | (54'd1 << 53);
        foreach (ill[k]) begin
            plan(ill[k], 0, 0, 1'b0);
            drive_instr(exp_a_q.size());
            foreach (exp_a_q[i]) begin
                n_chk++;
                if (obs_a_q[i] !== exp_a_q[i] || obs_b_q[i] !== exp_b_q[i]) begin
                    n_fail++;
                    $display("FAIL illegal #%0d cyc%0d: got a=%h b=%h exp a=%h b=%h",
                             k, i, obs_a_q[i], obs_b_q[i], exp_a_q[i], exp_b_q[i]);
                end
            end
        end
    endtask

    task automatic test_priority();
        int bits[3] = '{45, 46, 47};
        foreach (bits[k]) begin
            plan(54'd1 << bits[k], 1, 2, 1'b1);
            drive_instr(exp_a_q.size());
            foreach (exp_a_q[i]) begin
                n_chk++;
                if (obs_a_q[i] !== exp_a_q[i] || obs_b_q[i] !== exp_b_q[i]) begin
                    n_fail++;
                    $display("FAIL priority bit%0d cyc%0d: got a=%h b=%h exp a=%h b=%h",
                             bits[k], i, obs_a_q[i], obs_b_q[i], exp_a_q[i], exp_b_q[i]);
                end
            end
        end
    endtask

    // Ten busy cycles: the long-wait instance completes, the short-wait one times out.
    task automatic test_muldiv_timeout();
        plan(54'd1 << 26, 0, 10, 1'b0);
        drive_instr(exp_a_q.size());
        foreach (exp_a_q[i]) begin
            n_chk++;
            if (obs_a_q[i] !== exp_a_q[i]) begin
                n_fail++;
                $display("FAIL div_wait64 cyc%0d: got %h exp %h", i, obs_a_q[i], exp_a_q[i]);
            end
        end
        foreach (exp_b_q[i]) begin
            n_chk++;
            if (obs_b_q[i] !== exp_b_q[i]) begin
                n_fail++;
                $display("FAIL div_timeout8 cyc%0d: got %h exp %h", i, obs_b_q[i], exp_b_q[i]);
            end
        end
        apply_reset();
    endtask

    task automatic test_back_to_back();
        int pick_tab[14] = '{3, 16, 17, 40, 45, 24, 26, 46, 30, 33, 47, 50, 50, 5};
        logic [N-1:0] ins;
        int b1, b2;
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 9))
                0: ins = '0;
                1: begin
                    b1 = $urandom_range(0, 53);
                    b2 = (b1 + $urandom_range(1, 53)) % 54;
                    ins = (54'd1 << b1) | (54'd1 << b2);
                end
                2, 3: ins = 54'd1 << $urandom_range(0, 53);
                default: ins = 54'd1 << pick_tab[$urandom_range(0, 13)];
            endcase
            plan(ins, $urandom_range(0, 5), $urandom_range(0, 8), 1'($urandom_range(0, 1)));
            drive_instr(exp_a_q.size());
            foreach (exp_a_q[i]) begin
                n_chk++;
                if (obs_a_q[i] !== exp_a_q[i] || obs_b_q[i] !== exp_b_q[i]) begin
                    n_fail++;
                    $display("FAIL b2b n%0d instr=%h cyc%0d: got a=%h b=%h exp a=%h b=%h",
                             n, ins, i, obs_a_q[i], obs_b_q[i], exp_a_q[i], exp_b_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_mdwait();
        plan(54'd1 << 26, 0, 20, 1'b0);
        drive_instr(6);
        for (int i = 0; i < 6; i++) begin
            n_chk++;
            if (obs_a_q[i] !== exp_a_q[i] || obs_b_q[i] !== exp_b_q[i]) begin
                n_fail++;
                $display("FAIL rst_mid pre cyc%0d: got a=%h b=%h exp a=%h b=%h",
                         i, obs_a_q[i], obs_b_q[i], exp_a_q[i], exp_b_q[i]);
            end
        end
        rst = 1'b0;
        ret_model = 0;
        #1;
        n_chk++;
        if (obs_a !== {ctl(0, 5'd0, 0, 0), 32'd0} || obs_b !== {ctl(0, 5'd0, 0, 0), 3'd0}) begin
            n_fail++;
            $display("FAIL rst_mid async: got a=%h b=%h exp a=%h b=%h", obs_a, obs_b,
                     {ctl(0, 5'd0, 0, 0), 32'd0}, {ctl(0, 5'd0, 0, 0), 3'd0});
        end
        @(negedge clk);
        rst = 1'b1;
        plan(54'd1 << 16, 0, 0, 1'b0);
        drive_instr(exp_a_q.size());
        foreach (exp_a_q[i]) begin
            n_chk++;
            if (obs_a_q[i] !== exp_a_q[i] || obs_b_q[i] !== exp_b_q[i]) begin
                n_fail++;
                $display("FAIL rst_mid post cyc%0d: got a=%h b=%h exp a=%h b=%h",
                         i, obs_a_q[i], obs_b_q[i], exp_a_q[i], exp_b_q[i]);
            end
        end
        decoded_instr = '0;
        #1;
        n_chk++;
        if (retired_a !== 32'd1 || retired_b !== 3'd1) begin
            n_fail++;
            $display("FAIL rst_mid retired: got a=%0d b=%0d exp 1", retired_a, retired_b);
        end
    endtask

    initial begin
        test_reset();
        test_jump();
        test_alu_short();
        test_mem_stall();
        test_muldiv();
        test_teq();
        test_illegal();
        test_priority();
        test_muldiv_timeout();
        test_back_to_back();
        test_reset_mid_mdwait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_chk, n_fail);
        $fatal(1);
    end

endmodule
